dbg_avm_master: RTL and testbench
=================================

Name: dbg_avm_master

Overview:
- Avalon-MM initiator for the debug bridge.
- Accepts one command at a time from a local requester (debug sequencer or host shim) and drives the bridge's m0-style slave port.
- Read commands are issued as bursts; returned beats are forwarded as a response stream. Writes (e.g. CPU stop/run/step commands) are single-beat.
- A per-command timeout guarantees the requester always gets a terminating response, even when the slave stalls indefinitely (e.g. waiting for a CPU bus cycle that never ends).

Parameters:
- ADDR_W, 20, Avalon byte-address width.
- TIMEOUT_CYCLES, 1024, idle cycles allowed in REQ or RDATA before abort; legal range 2..65535.

Ports:
- clk_sys  in  1  core clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle (cmd_valid && cmd_ready).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_burst  in  7  read beat count; 0 is treated as 1; ignored for writes.
- m_address  out  ADDR_W  Avalon address.
- m_read  out  1  Avalon read request.
- m_write  out  1  Avalon write request.
- m_writedata  out  32  Avalon write data.
- m_burstcount  out  7  Avalon burst count; always 1 on writes.
- m_byteenable  out  4  always 4'hF while m_read or m_write is high, else 0.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  32  read beat data.
- m_readdatavalid  in  1  read beat strobe.
- rsp_valid  out  1  one-cycle response beat.
- rsp_data  out  32  read data; 0 for write acks and timeouts.
- rsp_last  out  1  final beat of the command.
- rsp_timeout  out  1  with rsp_valid: command aborted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE; beat and timeout counters cleared.
- Reset mid-operation aborts immediately. No response is emitted for the aborted command.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr, wdata, burst (0 becomes 1) and op; go to REQ next cycle with m_read or m_write high.
  - m_readdatavalid is ignored in IDLE.
- REQ:
  - Address, data, burstcount and byteenable are held stable.
  - The request is accepted on the cycle m_read or m_write is high and m_waitrequest is low. The request deasserts on the following edge.
  - Read accepted: go to RDATA.
  - Write accepted: go to IDLE and pulse rsp_valid = 1, rsp_last = 1, rsp_data = 0 on the next cycle.
- RDATA:
  - Each m_readdatavalid produces, one cycle later, rsp_valid = 1 with rsp_data = the registered m_readdata.
  - Beat counter increments per beat. rsp_last = 1 on beat == burst, then go to IDLE.
  - m_readdatavalid arriving in the same cycle as the read acceptance in REQ is counted.
- Timeout:
  - The counter clears on entering REQ or RDATA and on every readdatavalid beat; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1: drop m_read/m_write and pulse rsp_valid = 1, rsp_timeout = 1, rsp_last = 1, rsp_data = 0. Go to IDLE.
  - Beats already forwarded stand; late beats are ignored in IDLE.
- Back-to-back: cmd_ready reasserts in the cycle after the final response. Minimum write-to-write period is 3 cycles with zero wait states.
- Response interface has no backpressure; the requester must always sink rsp_valid.

Test Plan:
- Read burst: cmd_addr = 0x00008, burst = 4; slave waits 2 cycles, then returns 0x11, 0x22, 0x33, 0x44 -> m_burstcount = 4 held through the stall; four rsp_valid beats in order; rsp_last only on 0x44; busy low afterwards.
- Write stall: cmd_wdata = 0x01000000, m_waitrequest high for 5 cycles -> m_write and m_writedata stable for 6 cycles, m_burstcount = 1, m_byteenable = F; one ack with rsp_data = 0, rsp_last = 1.
- Burst 0: cmd_burst = 0 -> m_burstcount = 1; single beat 0xDEADBEEF returned with rsp_last = 1.
- Timeout: TIMEOUT_CYCLES = 16, m_waitrequest stuck high on a write 0x00000000 -> m_write drops after 16 cycles; rsp_timeout = 1, rsp_last = 1; a subsequent read completes normally.
- Partial burst timeout: burst = 4, slave returns 2 beats then stops -> 2 data beats, then a timeout beat; late 3rd beat in IDLE produces no rsp_valid.
- Reset and busy: cmd_valid held while busy -> cmd_ready = 0, no second accept; reset asserted mid-burst -> m_read = 0 and cmd_ready = 1 immediately, no rsp_valid.

Source files
------------

// File: rtl/dbg_avm_master.sv
// dbg_avm_master - Avalon-MM initiator for the debug bridge.
//
// Takes one command at a time from a local requester and runs it on an
// Avalon-MM slave port. Reads are issued as bursts, and every returned
// beat is forwarded on the response stream. Writes are single-beat and
// produce one acknowledge beat. A per-command timeout makes sure the
// requester always gets a terminating response, even if the slave
// stalls forever.
//
// Ports
//   clk_sys, reset         : core clock; asynchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake (accept = valid && ready)
//   cmd_write              : 1 = write, 0 = read
//   cmd_addr/wdata/burst   : byte address, write data, read beat count (0 -> 1)
//   m_*                    : Avalon-MM initiator signals
//   rsp_valid/data/last    : response beats (no backpressure)
//   rsp_timeout            : qualifies rsp_valid; the command was aborted
//   busy                   : a command is in progress
module dbg_avm_master #(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [6:0]        cmd_burst,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [6:0]        m_burstcount,
    output logic [3:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              rsp_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2
    } state_e;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [6:0]         burst_q, burst_d;
    logic               write_q, write_d;
    logic [6:0]         beat_q, beat_d;
    logic [15:0]        tmo_q, tmo_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_last_q, rsp_last_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic               accept_ok;
    logic               req_acc;
    logic               beat_now;

    // A response beat always occupies one IDLE cycle before the next command
    // is taken, giving the 3-cycle minimum write-to-write period.
    assign accept_ok = (state_q == S_IDLE) && !rsp_valid_q;
    assign req_acc   = (state_q == S_REQ) && !m_waitrequest;
    // A beat that arrives in the same cycle the read is accepted is counted.
    assign beat_now  = m_readdatavalid &&
                       ((state_q == S_RDATA) || (req_acc && !write_q));

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            burst_q       <= '0;
            write_q       <= 1'b0;
            beat_q        <= '0;
            tmo_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_last_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            burst_q       <= burst_d;
            write_q       <= write_d;
            beat_q        <= beat_d;
            tmo_q         <= tmo_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_last_q    <= rsp_last_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        burst_d       = burst_q;
        write_d       = write_q;
        beat_d        = beat_q;
        tmo_d         = tmo_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = '0;
        rsp_last_d    = 1'b0;
        rsp_timeout_d = 1'b0;

        if (beat_now) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = m_readdata;
            beat_d      = beat_q + 7'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (cmd_valid && accept_ok) begin
                    state_d = S_REQ;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    write_d = cmd_write;
                    burst_d = (cmd_write || (cmd_burst == 7'd0)) ? 7'd1 : cmd_burst;
                    beat_d  = '0;
                end
            end

            S_REQ: begin
                // Acceptance takes priority over a timeout in the same cycle.
                if (req_acc) begin
                    tmo_d = '0;
                    if (write_q) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                    end else if (beat_now && (beat_q + 7'd1 == burst_q)) begin
                        state_d    = S_IDLE;
                        rsp_last_d = 1'b1;
                    end else begin
                        state_d = S_RDATA;
                    end
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_last_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_RDATA: begin
                if (beat_now) begin
                    tmo_d = '0;
                    if (beat_q + 7'd1 == burst_q) begin
                        state_d    = S_IDLE;
                        rsp_last_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_last_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready    = accept_ok;
        busy         = (state_q != S_IDLE);
        m_read       = (state_q == S_REQ) && !write_q;
        m_write      = (state_q == S_REQ) && write_q;
        m_byteenable = (state_q == S_REQ) ? 4'hF : 4'h0;
        m_address    = addr_q;
        m_writedata  = wdata_q;
        m_burstcount = burst_q;
        rsp_valid    = rsp_valid_q;
        rsp_data     = rsp_data_q;
        rsp_last     = rsp_last_q;
        rsp_timeout  = rsp_timeout_q;
    end

endmodule

// File: tb/tb_dbg_avm_master.sv
// tb_dbg_avm_master - directed bench for dbg_avm_master (TIMEOUT_CYCLES = 16).
//
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_dbg_avm_master;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [6:0]  cmd_burst;
    logic [19:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [6:0]  m_burstcount;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_timeout;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    dbg_avm_master #(
        .ADDR_W         (20),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_burst       (cmd_burst),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_burstcount    (m_burstcount),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_last        (rsp_last),
        .rsp_timeout     (rsp_timeout),
        .busy            (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_beats [4];
        int cnt;
        rd_beats[0] = 32'h11;
        rd_beats[1] = 32'h22;
        rd_beats[2] = 32'h33;
        rd_beats[3] = 32'h44;

        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_addr        = '0;
        cmd_wdata       = '0;
        cmd_burst       = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;

        // Reset state
        tick();
        chk("rst cmd_ready",    32'(cmd_ready), 1);
        chk("rst busy",         32'(busy), 0);
        chk("rst m_read",       32'(m_read), 0);
        chk("rst m_write",      32'(m_write), 0);
        chk("rst m_byteenable", 32'(m_byteenable), 0);
        chk("rst m_burstcount", 32'(m_burstcount), 0);
        chk("rst rsp_valid",    32'(rsp_valid), 0);
        reset = 1'b0;
        tick();

        // Read burst of 4 with a 2-cycle stall
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00008; cmd_burst = 7'd4;
        tick();
        cmd_valid = 1'b0;
        m_waitrequest = 1'b1;
        chk("rd m_read",       32'(m_read), 1);
        chk("rd m_address",    32'(m_address), 32'h8);
        chk("rd m_burstcount", 32'(m_burstcount), 4);
        chk("rd m_byteenable", 32'(m_byteenable), 32'hF);
        chk("rd busy",         32'(busy), 1);
        chk("rd cmd_ready",    32'(cmd_ready), 0);
        tick();
        chk("rd stall m_read",       32'(m_read), 1);
        chk("rd stall m_burstcount", 32'(m_burstcount), 4);
        tick();
        m_waitrequest = 1'b0;
        chk("rd stall2 m_read", 32'(m_read), 1);
        tick();
        chk("rd dropped m_read", 32'(m_read), 0);
        for (int i = 0; i < 4; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata = rd_beats[i];
            tick();
            chk("rd rsp_valid", 32'(rsp_valid), 1);
            chk("rd rsp_data",  rsp_data, rd_beats[i]);
            chk("rd rsp_last",  32'(rsp_last), 32'(i == 3));
        end
        m_readdatavalid = 1'b0;
        chk("rd end busy",      32'(busy), 0);
        chk("rd end cmd_ready", 32'(cmd_ready), 0);
        tick();
        chk("rd after rsp_valid", 32'(rsp_valid), 0);
        chk("rd after cmd_ready", 32'(cmd_ready), 1);

        // Write with 5 wait states
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00100;
        cmd_wdata = 32'h01000000; cmd_burst = 7'd5;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("wr m_write",       32'(m_write), 1);
            chk("wr m_writedata",   m_writedata, 32'h01000000);
            chk("wr m_burstcount",  32'(m_burstcount), 1);
            chk("wr m_byteenable",  32'(m_byteenable), 32'hF);
            chk("wr rsp_valid low", 32'(rsp_valid), 0);
            m_waitrequest = (k < 5);
            tick();
        end
        m_waitrequest = 1'b0;
        chk("wr m_write dropped", 32'(m_write), 0);
        chk("wr ack rsp_valid",   32'(rsp_valid), 1);
        chk("wr ack rsp_data",    rsp_data, 0);
        chk("wr ack rsp_last",    32'(rsp_last), 1);
        chk("wr ack rsp_timeout", 32'(rsp_timeout), 0);
        tick();
        chk("wr after rsp_valid", 32'(rsp_valid), 0);

        // Burst 0 read, beat returned in the acceptance cycle
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00040; cmd_burst = 7'd0;
        tick();
        cmd_valid = 1'b0;
        chk("b0 m_burstcount", 32'(m_burstcount), 1);
        chk("b0 m_read",       32'(m_read), 1);
        m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
        tick();
        m_readdatavalid = 1'b0;
        chk("b0 rsp_valid", 32'(rsp_valid), 1);
        chk("b0 rsp_data",  rsp_data, 32'hDEADBEEF);
        chk("b0 rsp_last",  32'(rsp_last), 1);
        chk("b0 busy",      32'(busy), 0);
        tick();

        // Write timeout with waitrequest stuck high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00200; cmd_wdata = 32'h0;
        tick();
        cmd_valid = 1'b0;
        m_waitrequest = 1'b1;
        cnt = 0;
        while (m_write && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to m_write cycles", 32'(cnt), 16);
        chk("to rsp_valid",      32'(rsp_valid), 1);
        chk("to rsp_timeout",    32'(rsp_timeout), 1);
        chk("to rsp_last",       32'(rsp_last), 1);
        chk("to rsp_data",       rsp_data, 0);
        m_waitrequest = 1'b0;
        tick();

        // Normal read after the timeout
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00010; cmd_burst = 7'd2;
        tick();
        cmd_valid = 1'b0;
        chk("rd2 m_read", 32'(m_read), 1);
        tick();
        m_readdatavalid = 1'b1; m_readdata = 32'hA1;
        tick();
        chk("rd2 b0 data", rsp_data, 32'hA1);
        chk("rd2 b0 last", 32'(rsp_last), 0);
        m_readdata = 32'hA2;
        tick();
        m_readdatavalid = 1'b0;
        chk("rd2 b1 valid",   32'(rsp_valid), 1);
        chk("rd2 b1 data",    rsp_data, 32'hA2);
        chk("rd2 b1 last",    32'(rsp_last), 1);
        chk("rd2 b1 timeout", 32'(rsp_timeout), 0);
        tick();

        // Partial burst: 2 of 4 beats, then timeout, then a late beat
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00020; cmd_burst = 7'd4;
        tick();
        cmd_valid = 1'b0;
        tick();
        m_readdatavalid = 1'b1; m_readdata = 32'h55;
        tick();
        chk("pb b0 data", rsp_data, 32'h55);
        m_readdata = 32'h66;
        tick();
        m_readdatavalid = 1'b0;
        chk("pb b1 data", rsp_data, 32'h66);
        chk("pb b1 last", 32'(rsp_last), 0);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!rsp_valid && cnt < 40);
        chk("pb timeout cycles", 32'(cnt), 16);
        chk("pb rsp_timeout",    32'(rsp_timeout), 1);
        chk("pb rsp_last",       32'(rsp_last), 1);
        chk("pb rsp_data",       rsp_data, 0);
        chk("pb busy",           32'(busy), 0);
        m_readdatavalid = 1'b1; m_readdata = 32'h77;
        tick();
        m_readdatavalid = 1'b0;
        chk("pb late beat rsp_valid", 32'(rsp_valid), 0);
        tick();

        // Busy blocks a second command; reset mid-burst aborts silently
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00030; cmd_burst = 7'd2;
        tick();
        cmd_write = 1'b1; cmd_addr = 20'h003FC;
        m_waitrequest = 1'b1;
        chk("bsy cmd_ready", 32'(cmd_ready), 0);
        tick();
        chk("bsy m_address", 32'(m_address), 32'h30);
        chk("bsy m_read",    32'(m_read), 1);
        chk("bsy m_write",   32'(m_write), 0);
        m_waitrequest = 1'b0;
        tick();
        chk("bsy rdata cmd_ready", 32'(cmd_ready), 0);
        m_readdatavalid = 1'b1; m_readdata = 32'h99;
        tick();
        m_readdatavalid = 1'b0;
        cmd_valid = 1'b0;
        chk("bsy b0 data", rsp_data, 32'h99);
        reset = 1'b1;
        #1;
        chk("mid rst m_read",    32'(m_read), 0);
        chk("mid rst cmd_ready", 32'(cmd_ready), 1);
        chk("mid rst busy",      32'(busy), 0);
        chk("mid rst rsp_valid", 32'(rsp_valid), 0);
        tick();
        reset = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hAB;
        tick();
        m_readdatavalid = 1'b0;
        chk("post rst rsp_valid", 32'(rsp_valid), 0);
        chk("post rst busy",      32'(busy), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
